// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states
// and small op-decode helpers used by the unit, control_unit and the bench.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_t;

  // op[1] selects divide, op[0] selects unsigned.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the HI/LO registers. One result bit per
// cycle: shift-add multiply or restoring divide on operand magnitudes, then a
// sign-fix cycle that writes hi/lo. Divide by zero completes immediately.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mdu_state_t       state;
  logic             is_div;
  logic             neg_q;      // product / quotient must be negated
  logic             neg_r;      // remainder must be negated (negative dividend)
  logic [WIDTH:0]   opnd;       // multiplicand / divisor magnitude
  logic [2*WIDTH:0] acc;        // {upper W+1 bits, lower W bits}
  logic [CNT_W-1:0] cnt;

  // Operand conditioning
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH:0]   b_ext, b_mag;

  // Iteration datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH:0]   acc_step;

  // Result conditioning
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Magnitudes of the incoming operands and the signs the result needs.
  always_comb begin
    a_neg = op_is_signed(op) & a[WIDTH-1];
    b_neg = op_is_signed(op) & b[WIDTH-1];
    // The dividend/multiplier magnitude is at most 2**(WIDTH-1) when signed, so
    // its two's-complement negation read as unsigned is exact in WIDTH bits.
    a_mag = a_neg ? -a : a;
    b_ext = {b_neg, b};
    b_mag = b_neg ? -b_ext : b_ext;
  end

  // One multiply or divide step on the accumulator.
  always_comb begin
    // NOTE: every always_comb output is assigned up front so no path can
    // leave it unassigned and infer a latch.
    acc_step  = acc;
    mul_sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? opnd : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {1'b0, opnd};
    if (is_div) begin
      // Restoring division: keep the trial difference only when it did not borrow.
      if (div_diff[WIDTH+1])
        acc_step = {div_shift, acc[WIDTH-2:0], 1'b0};
      else
        acc_step = {div_diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {1'b0, mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Signed results from the unsigned magnitudes left in the accumulator.
  always_comb begin
    prod     = acc[2*WIDTH-1:0];
    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM with registered handshake outputs and the hi/lo result registers.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state  <= IDLE;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            is_div <= op_is_div(op);
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            opnd   <= b_mag;
            acc    <= {{(WIDTH+1){1'b0}}, a_mag};
            cnt    <= '0;
            if (op_is_div(op) && (b == '0)) begin
              state <= DONE;
              done  <= 1'b1;
              div0  <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT)
            state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): directed corner cases plus
// randomized operations compared against an arithmetic reference model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] hi, lo;
  logic         busy, done, div0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model result registers.
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .hi   (hi),
    .lo   (lo),
    .busy (busy),
    .done (done),
    .div0 (div0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Arithmetic model: updates m_hi/m_lo and reports a zero divisor.
  task automatic model_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output bit z);
    longint       sx, sy, sq, sr;
    logic [63:0]  p;
    z = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      MDU_MULT: begin
        p = 64'(sx * sy);
        {m_hi, m_lo} = p;
      end
      MDU_MULTU: begin
        p = {32'd0, x} * {32'd0, y};
        {m_hi, m_lo} = p;
      end
      MDU_DIV: begin
        if (y == 0) z = 1'b1;
        else begin
          sq = sx / sy;
          sr = sx % sy;
          m_lo = sq[W-1:0];
          m_hi = sr[W-1:0];
        end
      end
      default: begin
        if (y == 0) z = 1'b1;
        else begin
          m_lo = x / y;
          m_hi = x % y;
        end
      end
    endcase
  endtask

  // Issue one operation and follow it to its done pulse. When chained, start is
  // raised in the current (done) cycle; spur_cyc>0 raises a stray start then.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit chained, input int spur_cyc);
    int  t0, busy_cnt, rel;
    bit  seen, z;
    model_op(o, x, y, z);
    if (!chained) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1; op = o; a = x; b = y;
    t0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    busy_cnt = 0;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (spur_cyc > 0 && rel == spur_cyc) begin
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
      end
      if (spur_cyc > 0 && rel == spur_cyc + 1) start = 1'b0;
    end
    start = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(cyc - t0), z ? 64'd1 : 64'(W + 2));
    check("busy_cycles", 64'(busy_cnt), z ? 64'd0 : 64'(W + 1));
    check("busy_at_done", 64'(busy), 64'd0);
    check("div0", 64'(div0), 64'(z));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int done_cnt;
    reset = 1'b1; start = 1'b0; op = MDU_MULT; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_div0", 64'(div0), 64'd0);
    reset = 1'b0;

    // Directed cases with values worked out by hand.
    do_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 0);
    check("t1_hi", 64'(hi), 64'hFFFF_FFFF);
    check("t1_lo", 64'(lo), 64'hFFFF_FFEB);
    do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    check("t2_hi", 64'(hi), 64'hFFFF_FFFE);
    check("t2_lo", 64'(lo), 64'h0000_0001);
    do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    check("t3_lo", 64'(lo), 64'hFFFF_FFFD);
    check("t3_hi", 64'(hi), 64'hFFFF_FFFF);
    do_op(MDU_DIVU, 32'd100, 32'd7, 1'b0, 0);
    check("t3u_lo", 64'(lo), 64'd14);
    check("t3u_hi", 64'(hi), 64'd2);
    do_op(MDU_DIVU, 32'd100, 32'd0, 1'b0, 0);
    check("t4_hi", 64'(hi), 64'd2);
    check("t4_lo", 64'(lo), 64'd14);
    do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5);
    check("t5_lo", 64'(lo), 64'h8000_0000);
    check("t5_hi", 64'(hi), 64'd0);

    // Reset in cycle 10 of a MULT aborts it.
    @(posedge clk);
    #1;
    start = 1'b1; op = MDU_MULT; a = 32'd12345; b = 32'd678;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_hold_lo", 64'(lo), 64'd0);

    // Back-to-back: second start issued in the DONE cycle.
    do_op(MDU_MULT, 32'hFFFF_FF00, 32'd3, 1'b0, 0);
    do_op(MDU_DIVU, 32'hDEAD_BEEF, 32'd1234, 1'b1, 0);
    do_op(MDU_DIV, 32'd5, 32'd0, 1'b1, 0);
    do_op(MDU_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0);

    // Randomized operations, some chained, some with a stray start while busy.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] ro;
      ro = 2'($urandom);
      do_op(ro, pick_operand(), pick_operand(), 1'($urandom), ($urandom_range(0, 3) == 0) ? 7 : 0);
    end

    // hi/lo hold between operations.
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("hold_hi", 64'(hi), 64'(m_hi));
    check("hold_lo", 64'(lo), 64'(m_lo));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
